// File: rtl/riscv_decoder_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, trap causes, control-word bit positions.
// Optional M-extension decode is enabled with RISCV_DECODER_RV32M_EN (see riscv_decoder.sv).
package riscv_decoder_pkg;

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [31:0] CauseIllegal    = 32'd2;
  localparam logic [31:0] CauseBreakpoint = 32'd3;
  localparam logic [31:0] CauseEcallM     = 32'd11;

  localparam int MemValidBit = 4;
  localparam int MemStoreBit = 3;
  localparam int CsrValidBit = 4;
  localparam int CsrReadBit  = 3;
  localparam int CsrWriteBit = 2;

  localparam logic [31:0] InstMret   = 32'h30200073;
  localparam logic [31:0] InstEcall  = 32'h00000073;
  localparam logic [31:0] InstEbreak = 32'h00100073;
  localparam logic [31:0] InstWfi    = 32'h10500073;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmZ
  } immFmtT;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: reassembles the immediate of the selected format,
// sign-extended from inst[31] (zimm is zero-extended).
module riscv_imm_gen
  import riscv_decoder_pkg::*;
(
  input  logic [31:0] inst,
  input  immFmtT      fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
      ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ImmU:    imm = {inst[31:12], 12'b0};
      ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      ImmZ:    imm = {27'b0, inst[19:15]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decoder.sv
// RV32I decode stage: legality check, control decode and registered outputs with a held exception.
// Define RISCV_DECODER_RV32M_EN to accept the M-extension OP encodings (funct7 = 0000001).
module riscv_decoder
  import riscv_decoder_pkg::*;
(
  input  logic        Clk,
  input  logic        RstN,
  input  logic        En,
  input  logic [31:0] DataInst,
  output logic [4:0]  SelRS1,
  output logic [4:0]  SelRS2,
  output logic [4:0]  SelD,
  output logic [31:0] DataIMM,
  output logic        RegDwe,
  output logic [6:0]  AluOp,
  output logic [15:0] AluFunc,
  output logic [4:0]  MemOp,
  output logic [4:0]  CsrOp,
  output logic [11:0] CsrAddr,
  output logic        TrapExit,
  output logic        MultycyAlu,
  output logic        Int,
  output logic [31:0] IntData,
  input  logic        IntAck
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        legal;
  logic        envExc;
  logic [31:0] envCause;
  logic        wantWrite;
  logic        decTrap;
  logic        decMul;
  logic [4:0]  memSel;
  logic [4:0]  csrSel;
  immFmtT      immFmt;
  logic [31:0] immRaw;
  logic        excTaken;
  logic [31:0] excCause;

  assign opcode = DataInst[6:0];
  assign funct3 = DataInst[14:12];
  assign funct7 = DataInst[31:25];
  assign rd     = DataInst[11:7];
  assign rs1    = DataInst[19:15];

  riscv_imm_gen immGen (
    .inst (DataInst),
    .fmt  (immFmt),
    .imm  (immRaw)
  );

  always_comb begin
    legal     = 1'b1;
    envExc    = 1'b0;
    envCause  = CauseIllegal;
    wantWrite = 1'b0;
    decTrap   = 1'b0;
    decMul    = 1'b0;
    memSel    = '0;
    csrSel    = '0;
    immFmt    = ImmNone;
    case (opcode)
      OpLui, OpAuipc: begin
        immFmt    = ImmU;
        wantWrite = 1'b1;
      end
      OpJal: begin
        immFmt    = ImmJ;
        wantWrite = 1'b1;
      end
      OpJalr: begin
        legal     = (funct3 == 3'b000);
        immFmt    = ImmI;
        wantWrite = 1'b1;
      end
      OpBranch: begin
        legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
        immFmt = ImmB;
      end
      OpLoad: begin
        legal     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        immFmt    = ImmI;
        wantWrite = 1'b1;
        memSel    = {2'b10, funct3};
      end
      OpStore: begin
        legal  = funct3 inside {3'b000, 3'b001, 3'b010};
        immFmt = ImmS;
        memSel = {2'b11, funct3};
      end
      OpImm: begin
        immFmt    = ImmI;
        wantWrite = 1'b1;
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      OpReg: begin
        wantWrite = 1'b1;
        if (funct7 == 7'b0000000)
          legal = 1'b1;
        else if (funct7 == 7'b0100000)
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        else if (funct7 == 7'b0000001) begin
`ifdef RISCV_DECODER_RV32M_EN
          legal  = 1'b1;
          decMul = 1'b1;
`else
          legal  = 1'b0;
`endif
        end else
          legal = 1'b0;
      end
      OpMiscMem: legal = (funct3[2:1] == 2'b00);
      OpSystem: begin
        // funct3 = 000 holds only exact privileged encodings; anything else there is illegal
        if (funct3 == 3'b000) begin
          if (DataInst == InstEcall) begin
            envExc   = 1'b1;
            envCause = CauseEcallM;
          end else if (DataInst == InstEbreak) begin
            envExc   = 1'b1;
            envCause = CauseBreakpoint;
          end else if (DataInst == InstMret)
            decTrap = 1'b1;
          else if (DataInst != InstWfi)
            legal = 1'b0;
        end else if (funct3 == 3'b100)
          legal = 1'b0;
        else begin
          wantWrite           = 1'b1;
          immFmt              = funct3[2] ? ImmZ : ImmNone;
          csrSel[CsrValidBit] = 1'b1;
          csrSel[CsrReadBit]  = !((funct3[1:0] == 2'b01) && (rd == 5'd0));
          csrSel[CsrWriteBit] = !(funct3[1] && (rs1 == 5'd0));
          csrSel[1:0]         = funct3[1:0];
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign excTaken = !legal || envExc;
  assign excCause = legal ? envCause : CauseIllegal;

  // Decoded controls are suppressed whenever the instruction traps
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      SelRS1     <= '0;
      SelRS2     <= '0;
      SelD       <= '0;
      DataIMM    <= '0;
      RegDwe     <= 1'b0;
      AluOp      <= '0;
      AluFunc    <= '0;
      MemOp      <= '0;
      CsrOp      <= '0;
      CsrAddr    <= '0;
      TrapExit   <= 1'b0;
      MultycyAlu <= 1'b0;
    end else if (En) begin
      SelRS1     <= rs1;
      SelRS2     <= DataInst[24:20];
      SelD       <= rd;
      DataIMM    <= excTaken ? 32'd0 : immRaw;
      RegDwe     <= wantWrite && (rd != 5'd0) && !excTaken;
      AluOp      <= opcode;
      AluFunc    <= {6'b0, funct7, funct3};
      MemOp      <= excTaken ? 5'd0 : memSel;
      CsrOp      <= excTaken ? 5'd0 : csrSel;
      CsrAddr    <= DataInst[31:20];
      TrapExit   <= decTrap && !excTaken;
      MultycyAlu <= decMul && !excTaken;
    end
  end

  // A pending cause is sticky; only an acknowledge frees the slot for a newer exception
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Int     <= 1'b0;
      IntData <= '0;
    end else if (En && excTaken && (!Int || IntAck)) begin
      Int     <= 1'b1;
      IntData <= excCause;
    end else if (IntAck) begin
      Int     <= 1'b0;
      IntData <= '0;
    end
  end

endmodule

// File: tb/tb_riscv_decoder.sv
// Self-checking bench for riscv_decoder: directed vector table, reset sequences and
// randomized instructions compared against a rule-level reference model.
module tb_riscv_decoder;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        En;
  logic [31:0] DataInst;
  logic        IntAck;
  logic [4:0]  SelRS1, SelRS2, SelD;
  logic [31:0] DataIMM;
  logic        RegDwe;
  logic [6:0]  AluOp;
  logic [15:0] AluFunc;
  logic [4:0]  MemOp, CsrOp;
  logic [11:0] CsrAddr;
  logic        TrapExit, MultycyAlu, Int;
  logic [31:0] IntData;

  int nChecks = 0;
  int nFails  = 0;

  riscv_decoder dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .En         (En),
    .DataInst   (DataInst),
    .SelRS1     (SelRS1),
    .SelRS2     (SelRS2),
    .SelD       (SelD),
    .DataIMM    (DataIMM),
    .RegDwe     (RegDwe),
    .AluOp      (AluOp),
    .AluFunc    (AluFunc),
    .MemOp      (MemOp),
    .CsrOp      (CsrOp),
    .CsrAddr    (CsrAddr),
    .TrapExit   (TrapExit),
    .MultycyAlu (MultycyAlu),
    .Int        (Int),
    .IntData    (IntData),
    .IntAck     (IntAck)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        dwe;
    logic [6:0]  aluOp;
    logic [15:0] aluFunc;
    logic [4:0]  memOp, csrOp;
    logic [11:0] csrAddr;
    logic        trap, multy;
    logic        exc;
    logic [31:0] cause;
  } outT;

  typedef struct {
    logic [31:0] inst;
    logic        en, ack;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        dwe;
    logic [6:0]  aluOp;
    logic [4:0]  memOp, csrOp;
    logic        trap, multy, intr;
    logic [31:0] intData;
  } vecT;

  outT         mOut;
  logic        mInt;
  logic [31:0] mIntData;

  function automatic logic [31:0] sx(input logic [31:0] v, input int w);
    logic signed [31:0] t;
    t = v << (32 - w);
    return 32'(t >>> (32 - w));
  endfunction

  // Reference decode: direct reading of the instruction-set rules
  function automatic outT refDecode(input logic [31:0] i);
    outT o;
    logic ok, writes, mEn;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
`ifdef RISCV_DECODER_RV32M_EN
    mEn = 1'b1;
`else
    mEn = 1'b0;
`endif
    o = '{default: '0};
    o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.rd = i[11:7];
    o.aluOp = i[6:0]; o.aluFunc = {6'b0, f7, f3}; o.csrAddr = i[31:20];
    ok = 1'b1; writes = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin o.imm = {i[31:12], 12'h000}; writes = 1'b1; end
      7'h6F: begin o.imm = sx(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); writes = 1'b1; end
      7'h67: begin ok = (f3 == 3'd0); o.imm = sx(32'(i[31:20]), 12); writes = 1'b1; end
      7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); o.imm = sx(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
      7'h03: begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        o.imm = sx(32'(i[31:20]), 12); writes = 1'b1; o.memOp = {2'b10, f3};
      end
      7'h23: begin ok = (f3 < 3'd3); o.imm = sx(32'({i[31:25], i[11:7]}), 12); o.memOp = {2'b11, f3}; end
      7'h13: begin
        o.imm = sx(32'(i[31:20]), 12); writes = 1'b1;
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
      end
      7'h33: begin
        writes = 1'b1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && mEn);
        o.multy = (f7 == 7'h01) && mEn;
      end
      7'h0F: ok = (f3 < 3'd2);
      7'h73: begin
        if (f3 == 3'd0) begin
          if (i == 32'h00000073) begin o.exc = 1'b1; o.cause = 32'd11; end
          else if (i == 32'h00100073) begin o.exc = 1'b1; o.cause = 32'd3; end
          else if (i == 32'h30200073) o.trap = 1'b1;
          else if (i != 32'h10500073) ok = 1'b0;
        end else if (f3 == 3'd4) ok = 1'b0;
        else begin
          writes = 1'b1;
          o.csrOp = {1'b1, !(f3[1:0] == 2'd1 && i[11:7] == 5'd0), !(f3[1] && i[19:15] == 5'd0), f3[1:0]};
          if (f3[2]) o.imm = {27'b0, i[19:15]};
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin o.exc = 1'b1; o.cause = 32'd2; end
    if (o.exc) begin
      o.imm = '0; o.memOp = '0; o.csrOp = '0; o.trap = 1'b0; o.multy = 1'b0; writes = 1'b0;
    end
    o.dwe = writes && (i[11:7] != 5'd0);
    return o;
  endfunction

  task automatic modelStep(input logic [31:0] inst, input logic en, input logic ack);
    outT d;
    d = refDecode(inst);
    if (en) mOut = d;
    if (en && d.exc && (!mInt || ack)) begin
      mInt = 1'b1; mIntData = d.cause;
    end else if (ack) begin
      mInt = 1'b0; mIntData = '0;
    end
  endtask

  task automatic modelReset();
    mOut = '{default: '0};
    mInt = 1'b0;
    mIntData = '0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic en, input logic ack);
    DataInst = inst; En = en; IntAck = ack;
    @(posedge Clk);
    modelStep(inst, en, ack);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".SelRS1"}, 32'(SelRS1), 32'(mOut.rs1));
    cmp({tag, ".SelRS2"}, 32'(SelRS2), 32'(mOut.rs2));
    cmp({tag, ".SelD"}, 32'(SelD), 32'(mOut.rd));
    cmp({tag, ".DataIMM"}, DataIMM, mOut.imm);
    cmp({tag, ".RegDwe"}, 32'(RegDwe), 32'(mOut.dwe));
    cmp({tag, ".AluOp"}, 32'(AluOp), 32'(mOut.aluOp));
    cmp({tag, ".AluFunc"}, 32'(AluFunc), 32'(mOut.aluFunc));
    cmp({tag, ".MemOp"}, 32'(MemOp), 32'(mOut.memOp));
    cmp({tag, ".CsrOp"}, 32'(CsrOp), 32'(mOut.csrOp));
    cmp({tag, ".CsrAddr"}, 32'(CsrAddr), 32'(mOut.csrAddr));
    cmp({tag, ".TrapExit"}, 32'(TrapExit), 32'(mOut.trap));
    cmp({tag, ".MultycyAlu"}, 32'(MultycyAlu), 32'(mOut.multy));
    cmp({tag, ".Int"}, 32'(Int), 32'(mInt));
    cmp({tag, ".IntData"}, IntData, mIntData);
  endtask

  task automatic checkVec(input vecT v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    cmp({t, ".SelRS1"}, 32'(SelRS1), 32'(v.rs1));
    cmp({t, ".SelRS2"}, 32'(SelRS2), 32'(v.rs2));
    cmp({t, ".SelD"}, 32'(SelD), 32'(v.rd));
    cmp({t, ".DataIMM"}, DataIMM, v.imm);
    cmp({t, ".RegDwe"}, 32'(RegDwe), 32'(v.dwe));
    cmp({t, ".AluOp"}, 32'(AluOp), 32'(v.aluOp));
    cmp({t, ".MemOp"}, 32'(MemOp), 32'(v.memOp));
    cmp({t, ".CsrOp"}, 32'(CsrOp), 32'(v.csrOp));
    cmp({t, ".TrapExit"}, 32'(TrapExit), 32'(v.trap));
    cmp({t, ".MultycyAlu"}, 32'(MultycyAlu), 32'(v.multy));
    cmp({t, ".Int"}, 32'(Int), 32'(v.intr));
    cmp({t, ".IntData"}, IntData, v.intData);
  endtask

  function automatic vecT mkVec(input logic [31:0] inst, input logic en, input logic ack,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic dwe, input logic [6:0] aluOp,
                                input logic [4:0] memOp, input logic [4:0] csrOp, input logic trap,
                                input logic multy, input logic intr, input logic [31:0] intData);
    vecT v;
    v.inst = inst; v.en = en; v.ack = ack; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.dwe = dwe; v.aluOp = aluOp; v.memOp = memOp; v.csrOp = csrOp;
    v.trap = trap; v.multy = multy; v.intr = intr; v.intData = intData;
    return v;
  endfunction

  function automatic logic [31:0] genInst();
    logic [31:0] r;
    logic [6:0]  ops [11];
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 16);
    if (k < 11) begin
      r[6:0] = ops[k];
      if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
      if ($urandom_range(0, 3) == 0) r[19:15] = 5'd0;
      if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: r[31:25] = 7'h01;
        endcase
      end
    end else if (k == 11) r = 32'h00000073;
    else if (k == 12) r = 32'h00100073;
    else if (k == 13) r = 32'h30200073;
    else if (k == 14) r = 32'h10500073;
    return r;
  endfunction

  vecT vecs [15];

  initial begin
`ifdef RISCV_DECODER_RV32M_EN
    vecT mulVec;
    mulVec = mkVec(32'h022081B3, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 7'h33, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
`else
    vecT mulVec;
    mulVec = mkVec(32'h022081B3, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 7'h33, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd2);
`endif
    vecs[0]  = mkVec(32'h00500093, 1'b1, 1'b0, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 7'h13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mkVec(32'h0020A423, 1'b1, 1'b0, 5'd1, 5'd2, 5'd8, 32'd8, 1'b0, 7'h23, 5'b11010, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[2]  = mkVec(32'h123450B7, 1'b1, 1'b0, 5'd8, 5'd3, 5'd1, 32'h12345000, 1'b1, 7'h37, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[3]  = mkVec(32'h300022F3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 1'b1, 7'h73, 5'd0, 5'b11010, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[4]  = mkVec(32'h00000000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 7'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd2);
    vecs[5]  = mkVec(32'h00500093, 1'b1, 1'b0, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 7'h13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd2);
    vecs[6]  = mkVec(32'h00000073, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd2);
    vecs[7]  = mkVec(32'h00500093, 1'b1, 1'b1, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 7'h13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    vecs[8]  = mkVec(32'h00000073, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd11);
    vecs[9]  = mkVec(32'h00100073, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd3);
    vecs[10] = mkVec(32'h30200073, 1'b1, 1'b1, 5'd0, 5'd2, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[11] = mkVec(32'h00500093, 1'b0, 1'b0, 5'd0, 5'd2, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[12] = mkVec(32'h00000000, 1'b0, 1'b0, 5'd0, 5'd2, 5'd0, 32'd0, 1'b0, 7'h73, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    vecs[13] = mulVec;
    vecs[14] = mulVec;
    vecs[14].inst = 32'h00000000; vecs[14].en = 1'b0; vecs[14].ack = 1'b1;
    vecs[14].intr = 1'b0; vecs[14].intData = 32'd0;

    RstN = 1'b0; En = 1'b0; IntAck = 1'b0; DataInst = 32'h00500093;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge Clk);
    RstN = 1'b1;

    for (int n = 0; n < 15; n++) begin
      applyStimulus(vecs[n].inst, vecs[n].en, vecs[n].ack);
      checkVec(vecs[n], n);
    end

    // Reset asserted between edges while an instruction is presented: it must never land
    applyStimulus(32'h00000000, 1'b1, 1'b0);
    DataInst = 32'h123450B7; En = 1'b1; IntAck = 1'b0;
    #2 RstN = 1'b0;
    modelReset();
    #1 checkOutput("midReset");
    @(posedge Clk);
    #1 checkOutput("heldReset");
    RstN = 1'b1;

    for (int n = 0; n < 400; n++) begin
      applyStimulus(genInst(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
